// File: rtl/regfile_write_arbiter_if.sv
// ============================================================================
// regfile_write_arbiter_if
// ----------------------------------------------------------------------------
// Purpose: bundles every non-clock/non-reset signal of the register file write
// arbiter. The signals fall into four groups: the writeback request, the
// multi-cycle unit request/handshake, the scoreboard issue/check, and the
// register file write port.
//
// Modports:
//   master - the surrounding pipeline side. It drives the requests, the issue
//            info and the check indices, and observes the grant, hazard and
//            write port outputs.
//   slave  - the arbiter itself.
//
// Signals:
//   wb_valid/wb_rd/wb_data        writeback write request (primary)
//   mc_valid/mc_rd/mc_data        multi-cycle unit write request (secondary)
//   mc_ready                      write port free for the multi-cycle unit
//   issue_valid/issue_rd          long-latency op issued, destination register
//   chk_rs1/chk_rs2               source registers to hazard-check
//   hazard                        a checked source has a pending write
//   wb_stall                      writeback suppressed this cycle
//   rf_we/rf_waddr/rf_wdata       register file write port
// ============================================================================
interface regfile_write_arbiter_if;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_ready;

    logic        issue_valid;
    logic [4:0]  issue_rd;

    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        hazard;

    logic        wb_stall;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    modport master (
        output wb_valid, wb_rd, wb_data,
        output mc_valid, mc_rd, mc_data,
        input  mc_ready,
        output issue_valid, issue_rd,
        output chk_rs1, chk_rs2,
        input  hazard,
        input  wb_stall,
        input  rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data,
        input  mc_valid, mc_rd, mc_data,
        output mc_ready,
        input  issue_valid, issue_rd,
        input  chk_rs1, chk_rs2,
        output hazard,
        output wb_stall,
        output rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// regfile_write_arbiter
// ----------------------------------------------------------------------------
// Purpose: shares the single register file write port between the writeback
// stage (primary) and the multi-cycle unit (loads/mul/div, secondary). It also
// keeps a scoreboard of destination registers that have a multi-cycle write
// still pending, and uses that scoreboard to flag read-after-write hazards.
//
// Writeback normally wins the port. When the multi-cycle unit has been denied
// STARVE_LIMIT cycles in a row, the arbiter spends one FORCE cycle in which
// writeback is stalled and the multi-cycle write is guaranteed to go through.
//
// Parameters:
//   STARVE_LIMIT  consecutive denied multi-cycle cycles before writeback is
//                 forcibly stalled (1..15)
//
// Ports:
//   clk    clock; all state changes on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    regfile_write_arbiter_if.slave (requests, scoreboard, write port)
// ============================================================================
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    regfile_write_arbiter_if.slave  bus
);

    localparam logic [3:0] STARVE_CNT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WAIT  = 2'd1,
        ARB_FORCE = 2'd2
    } arb_state_t;

    arb_state_t  state_reg;
    arb_state_t  state_next;
    logic [3:0]  wait_cnt_reg;
    logic [3:0]  wait_cnt_next;
    logic [3:0]  wait_cnt_inc;

    logic        wb_grant;
    logic        mc_ready_raw;
    logic        mc_hs;
    logic        mc_denied;

    logic        rf_we_raw;
    logic [4:0]  rf_waddr_raw;
    logic [31:0] rf_wdata_raw;

    // x0 is never tracked, so the storage starts at bit 1.
    logic [31:1] busy_reg;
    logic [31:1] busy_set;
    logic [31:1] busy_clr;
    logic [31:0] busy_vec;

    // ------------------------------------------------------------------------
    // Arbiter state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ARB_IDLE;
            wait_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // Grant decision and write port mux
    // ------------------------------------------------------------------------
    always_comb begin
        wb_grant     = 1'b0;
        mc_ready_raw = 1'b0;
        rf_we_raw    = 1'b0;
        rf_waddr_raw = 5'd0;
        rf_wdata_raw = 32'd0;

        if (state_reg == ARB_FORCE) begin
            // Writeback is held off this cycle; the port belongs to the
            // multi-cycle unit regardless of what writeback presents.
            mc_ready_raw = 1'b1;
        end else if (bus.wb_valid && (bus.wb_rd != 5'd0)) begin
            wb_grant = 1'b1;
        end else begin
            // A writeback to x0 is a no-op, so it does not block the port.
            mc_ready_raw = 1'b1;
        end

        mc_hs     = bus.mc_valid && mc_ready_raw;
        mc_denied = bus.mc_valid && !mc_ready_raw;

        if (wb_grant) begin
            rf_we_raw    = 1'b1;
            rf_waddr_raw = bus.wb_rd;
            rf_wdata_raw = bus.wb_data;
        end else if (mc_hs && (bus.mc_rd != 5'd0)) begin
            rf_we_raw    = 1'b1;
            rf_waddr_raw = bus.mc_rd;
            rf_wdata_raw = bus.mc_data;
        end
    end

    // ------------------------------------------------------------------------
    // Arbiter next-state logic
    // ------------------------------------------------------------------------
    assign wait_cnt_inc = wait_cnt_reg + 4'd1;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;

        case (state_reg)
            ARB_IDLE, ARB_WAIT: begin
                if (mc_denied) begin
                    wait_cnt_next = wait_cnt_inc;
                    // Checked from IDLE too, so that STARVE_LIMIT=1 forces on
                    // the very first denied cycle.
                    if (wait_cnt_inc >= STARVE_CNT) begin
                        state_next = ARB_FORCE;
                    end else begin
                        state_next = ARB_WAIT;
                    end
                end else begin
                    // Either a handshake happened or the unit has nothing to
                    // write; both end the starvation episode.
                    state_next    = ARB_IDLE;
                    wait_cnt_next = 4'd0;
                end
            end
            ARB_FORCE: begin
                // mc_valid is held until handshake, so the grant in FORCE
                // always completes it.
                state_next    = ARB_IDLE;
                wait_cnt_next = 4'd0;
            end
            default: begin
                state_next    = ARB_IDLE;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Pending-write scoreboard
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_busy
            assign busy_set[gi] = bus.issue_valid && (bus.issue_rd == 5'(gi));
            assign busy_clr[gi] = mc_hs && (bus.mc_rd == 5'(gi));

            // A new issue to the same register outranks the completing write:
            // the newer op still owes a result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    busy_reg[gi] <= 1'b0;
                end else if (busy_set[gi]) begin
                    busy_reg[gi] <= 1'b1;
                end else if (busy_clr[gi]) begin
                    busy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign busy_vec = {busy_reg, 1'b0};

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The port outputs are combinational from the inputs, so they are gated
    // with rst_n directly to stay quiet for the whole reset window.
    assign bus.mc_ready = mc_ready_raw & rst_n;
    assign bus.rf_we    = rf_we_raw & rst_n;
    assign bus.rf_waddr = rst_n ? rf_waddr_raw : 5'd0;
    assign bus.rf_wdata = rst_n ? rf_wdata_raw : 32'd0;

    // Pure state decode: no path from any input.
    assign bus.wb_stall = (state_reg == ARB_FORCE);

    // busy_reg is cleared asynchronously, so no extra reset gating is needed.
    assign bus.hazard = busy_vec[bus.chk_rs1] | busy_vec[bus.chk_rs2];

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between the pipeline writeback stage (primary) and the multi-cycle unit (loads/mul/div, secondary). Holds a pending-write scoreboard of destination registers for hazard detection. Guarantees forward progress for the secondary requester by briefly stalling writeback. Sits between the WB stage, the multi-cycle unit and the register file write port.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive denied secondary cycles before writeback is forcibly stalled (legal 1..15)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wb_valid  in  1  writeback requests a write
- wb_rd  in  5  writeback destination register
- wb_data  in  32  writeback data
- mc_valid  in  1  multi-cycle unit requests a write; held until handshake
- mc_rd  in  5  multi-cycle destination register
- mc_data  in  32  multi-cycle data
- mc_ready  out  1  write port free for multi-cycle unit this cycle
- issue_valid  in  1  long-latency op issued this cycle
- issue_rd  in  5  its destination register
- chk_rs1  in  5  source register 1 to hazard-check
- chk_rs2  in  5  source register 2 to hazard-check
- hazard  out  1  either checked source has a pending multi-cycle write
- wb_stall  out  1  writeback write suppressed this cycle; WB must hold
- rf_we  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  32  register file write data

## Operation
- Arbiter FSM states: IDLE, WAIT, FORCE; 4-bit counter wait_cnt.
- IDLE/WAIT: writeback has priority. If wb_valid and wb_rd != 0: rf_we=1, rf_waddr=wb_rd, rf_wdata=wb_data, mc_ready=0. Otherwise mc_ready=1.
- FORCE: wb_stall=1, mc_ready=1, writeback not written; WB holds wb_* stable and presents again next cycle.
- Multi-cycle handshake = mc_valid && mc_ready. On handshake with mc_rd != 0: rf_we=1, rf_waddr=mc_rd, rf_wdata=mc_data. mc_rd == 0: handshake completes, rf_we=0.
- Denied cycle = mc_valid && !mc_ready. wait_cnt increments per denied cycle; cleared on handshake or mc_valid=0.
- Transitions: IDLE -> WAIT on denied cycle; WAIT -> FORCE on the denied cycle that makes wait_cnt reach STARVE_LIMIT; WAIT -> IDLE on handshake or mc_valid=0; FORCE -> IDLE unconditionally (handshake guaranteed since mc_valid held), wait_cnt cleared.
- Scoreboard busy[31:1], busy[0] constant 0.
  - Set: issue_valid && issue_rd != 0.
  - Clear: multi-cycle handshake with that mc_rd.
  - Same register set and cleared in one cycle: set wins.
  - Re-issue to a busy register keeps it busy; writeback writes never alter busy.
- hazard = busy[chk_rs1] | busy[chk_rs2]; x0 never hazards.
- rf_we never asserted for address 0.

## Timing
- rf_we/rf_waddr/rf_wdata, mc_ready: combinational from inputs and FSM state; register file captures at the same rising edge (zero added latency).
- wb_stall: decoded from registered state (FORCE), no input-to-output path.
- hazard: combinational from registered busy bits and chk_rs*; a clear takes effect after the handshake edge, when the register file already holds the data.
- Issue at edge N: hazard for that rd visible from cycle N+1.
- Worst-case multi-cycle wait: STARVE_LIMIT denied cycles, then grant in FORCE cycle (STARVE_LIMIT+1 total).
- Reset (rst_n=0, asynchronous): state IDLE, wait_cnt=0, busy all 0. While asserted: rf_we=0, mc_ready=0, wb_stall=0, hazard=0, rf_waddr=0, rf_wdata=0. Reset mid-FORCE or mid-WAIT discards state; pending writes are lost.

## Test plan
- wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF, mc_valid=0 -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, mc_ready=0.
- wb_valid=1, wb_rd=0; mc_valid=1, mc_rd=7, mc_data=0x12345678 -> rf_we=1, rf_waddr=7, mc_ready=1; no write to x0.
- STARVE_LIMIT=4, wb_valid=1 (rd=3) continuously, mc_valid=1 (rd=9) -> 4 cycles mc_ready=0, cycle 5 wb_stall=1, rf_waddr=9, mc_ready=1; cycle 6 wb_stall=0, writeback rd=3 written.
- issue_valid=1, issue_rd=10; next cycle chk_rs1=10 -> hazard=1; mc handshake rd=10 -> hazard=0 the following cycle; chk_rs2=0 -> hazard=0 throughout.
- Same cycle issue_rd=12 and mc handshake mc_rd=12 -> busy[12] remains 1, hazard=1 next cycle.
- Assert rst_n=0 asynchronously during FORCE with busy[4]=1 -> immediately wb_stall=0, mc_ready=0, rf_we=0; after release, hazard for chk_rs1=4 is 0 and state IDLE.
